// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle into architectural HI/LO, plus MTHI/MTLO writes.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic             isDiv;
  logic             negLo;
  logic             negHi;
  logic             bZero;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;
  logic [CntW-1:0]  count;

  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] aAbs;
  logic [WIDTH-1:0] bAbs;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divFits;
  logic [WIDTH-1:0] divDiff;
  logic [WIDTH-1:0] stepHi;
  logic [WIDTH-1:0] stepLo;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0] rawDividend;
  logic [WIDTH-1:0] resHi;
  logic [WIDTH-1:0] resLo;

  // op[0] clear selects the signed variants (MULT, DIV)
  always_comb begin
    aNeg = ~op[0] & ReadData1[WIDTH-1];
    bNeg = ~op[0] & ReadData2[WIDTH-1];
    aAbs = aNeg ? -ReadData1 : ReadData1;
    bAbs = bNeg ? -ReadData2 : ReadData2;
  end

  // Multiply keeps the multiplier in accLo and shifts the product down into it;
  // divide keeps the dividend in accLo and shifts quotient bits in from the right.
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, aMag} : '0);
    divShift = {accHi, accLo[WIDTH-1]};
    divFits  = divShift >= {1'b0, bMag};
    divDiff  = divShift[WIDTH-1:0] - bMag;
    if (isDiv) begin
      stepHi = divFits ? divDiff : divShift[WIDTH-1:0];
      stepLo = {accLo[WIDTH-2:0], divFits};
    end else begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], accLo[WIDTH-1:1]};
    end
  end

  always_comb begin
    product     = {accHi, accLo};
    rawDividend = negHi ? -aMag : aMag;
    if (!isDiv) begin
      {resHi, resLo} = negLo ? -product : product;
    end else if (bZero) begin
      resHi = rawDividend;
      resLo = '1;
    end else begin
      resHi = negHi ? -accHi : accHi;
      resLo = negLo ? -accLo : accLo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      HI          <= '0;
      LO          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      isDiv       <= 1'b0;
      negLo       <= 1'b0;
      negHi       <= 1'b0;
      bZero       <= 1'b0;
      aMag        <= '0;
      bMag        <= '0;
      accHi       <= '0;
      accLo       <= '0;
      count       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) HI <= ReadData1;
          if (lo_we) LO <= ReadData1;
          if (start) begin
            isDiv       <= op[1];
            aMag        <= aAbs;
            bMag        <= bAbs;
            negLo       <= aNeg ^ bNeg;
            negHi       <= aNeg;
            bZero       <= op[1] && (ReadData2 == '0);
            accHi       <= '0;
            accLo       <= op[1] ? aAbs : bAbs;
            count       <= CntW'(WIDTH);
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= CALC;
          end
        end
        CALC: begin
          accHi <= stepHi;
          accLo <= stepLo;
          count <= count - 1'b1;
          if (count == CntW'(1)) state <= FIX;
        end
        FIX: begin
          HI          <= resHi;
          LO          <= resLo;
          div_by_zero <= bZero;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative MIPS multiply/divide unit, directly downstream of the register file. It consumes ReadData1 (rs) and ReadData2 (rt) and executes MULT, MULTU, DIV and DIVU at one bit per cycle into architectural HI/LO registers. It also services MTHI and MTLO writes and drives HI/LO for MFHI/MFLO. Control holds the pipeline on busy.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  launch operation selected by op; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
ReadData1  input  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
ReadData2  input  WIDTH  rt operand (multiplier/divisor)
hi_we  input  1  MTHI: HI <= ReadData1
lo_we  input  1  MTLO: LO <= ReadData1
HI  output  WIDTH  HI register (MULT upper product / DIV remainder)
LO  output  WIDTH  LO register (MULT lower product / DIV quotient)
busy  output  1  operation in flight; control must stall MFHI/MFLO/start
done  output  1  one-cycle pulse, HI/LO just updated by result
div_by_zero  output  1  sticky-until-next-start flag, set with done when divisor was 0

Behaviour:
- Reset (async, any time): state IDLE; HI=0, LO=0, busy=0, done=0, div_by_zero=0; in-flight op aborted, no writeback.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE: start=1 at edge E0 latches op, |A|, |B| (magnitudes for signed ops, raw for unsigned), result sign(s), counter=WIDTH; clears div_by_zero; goes CALC; busy=1 from E0.
- CALC: one shift-add (mult) or restoring shift-subtract (div) step per edge; counter decrements; after WIDTH edges (E1..E32) -> FIX.
- FIX (edge E33): apply sign, write HI/LO, busy=0, done=1 for cycle after E33, -> IDLE. Latency: HI/LO valid 33 cycles after start edge. Back-to-back start accepted in the cycle done is high.
- Multiply: 2*WIDTH product; HI=upper, LO=lower. Signed: product negated (two's complement, 64-bit) iff signs of A,B differ.
- Divide: LO=quotient, HI=remainder. Signed: quotient truncates toward zero (negated iff signs differ), remainder takes dividend sign. Magnitudes held as unsigned WIDTH bits, so 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no flag).
- Divide by zero (DIV or DIVU, B=0): full latency; LO=all ones, HI=ReadData1 as latched (unsigned value of dividend); div_by_zero=1 with done.
- start while busy: ignored, no effect on current op.
- hi_we/lo_we: effective at edge only when not busy; ignored while busy. Same edge as accepted start: HI/LO take ReadData1 now, overwritten by result at E33. hi_we and lo_we together: both written.
- Operands are not required stable after E0.
- HI/LO outputs hold old values during CALC (no partial results visible).

Test Plan:
- Reset, then MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, done pulses once, busy low.
- MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0.
- DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007, div_by_zero=1. Next start clears the flag.
- During busy: start with new operands, and hi_we with ReadData1=0x1234 -> both ignored; first result intact. In IDLE, hi_we=1, ReadData1=0xABCD -> HI=0xABCD next cycle.
- Reset asserted 10 cycles into DIVU -> HI=LO=0, busy=0 immediately. No done pulse; subsequent MULTU 6x7 -> LO=42, HI=0.
